// File: rtl/wshb_if.sv
// wshb_if: Wishbone B4 bus bundle with master and slave views
interface wshb_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic cyc;
  logic stb;
  logic we;
  logic [AW-1:0] adr;
  logic [DW/8-1:0] sel;
  logic [2:0] cti;
  logic [1:0] bte;
  logic [DW-1:0] dat_ms;
  logic [DW-1:0] dat_sm;
  logic ack;
  logic err;
  logic rty;
  modport master (
    output cyc, stb, we, adr, sel, cti, bte, dat_ms,
    input  ack, err, rty, dat_sm
  );
  modport slave (
    input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
    output ack, err, rty, dat_sm
  );
endinterface

// File: rtl/wshb_arbiter.sv
// wshb_arbiter: fixed-priority vga/mire arbiter onto one sdram port with bounded mire tenure
module wshb_arbiter #(
  parameter int MIRE_QUANTUM = 16,
  parameter int PREEMPT_W = 16
) (
  input  logic clk,
  input  logic rst,
  wshb_if.slave wshb_ifs_vga,
  wshb_if.slave wshb_ifs_mire,
  wshb_if.master wshb_ifm_sdram,
  output logic [1:0] owner,
  output logic [PREEMPT_W-1:0] preempt_cnt
);
  typedef enum logic [1:0] {IDLE, VGA, MIRE, GAP} state_t;
  localparam logic [7:0] QUANTUM = 8'(MIRE_QUANTUM);
  state_t state, state_n;
  logic [7:0] tenure, tenure_n;
  logic vga_own, mire_own, beat, boundary, force_rel;
  assign vga_own = state == VGA;
  assign mire_own = state == MIRE;
  assign beat = wshb_ifm_sdram.ack | wshb_ifm_sdram.err | wshb_ifm_sdram.rty;
  assign boundary = wshb_ifm_sdram.cti == 3'b000 || wshb_ifm_sdram.cti == 3'b111;
  assign tenure_n = &tenure ? tenure : tenure + 8'd1;
  assign force_rel = mire_own & beat & boundary & wshb_ifs_vga.cyc & (tenure_n >= QUANTUM);
  // next grant: requests only taken from idle/gap, vga first; releases always go through gap
  always_comb begin
    state_n = state;
    case (state)
      IDLE, GAP: state_n = wshb_ifs_vga.cyc ? VGA : wshb_ifs_mire.cyc ? MIRE : IDLE;
      VGA:       state_n = wshb_ifs_vga.cyc ? VGA : GAP;
      MIRE:      state_n = (!wshb_ifs_mire.cyc || force_rel) ? GAP : MIRE;
      default:   state_n = IDLE;
    endcase
  end
  // grant state, registered owner code, tenure and saturating preemption count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 2'b00;
      tenure <= 8'd0;
      preempt_cnt <= '0;
    end else begin
      state <= state_n;
      owner <= state_n == VGA ? 2'b10 : state_n == MIRE ? 2'b01 : 2'b00;
      tenure <= mire_own ? (beat ? tenure_n : tenure) : 8'd0;
      if (force_rel && !(&preempt_cnt)) preempt_cnt <= preempt_cnt + PREEMPT_W'(1);
    end
  end
  // forward the owner's request to sdram; nothing leaves while idle or in the gap
  always_comb begin
    wshb_ifm_sdram.cyc = vga_own ? wshb_ifs_vga.cyc : mire_own & wshb_ifs_mire.cyc;
    wshb_ifm_sdram.stb = vga_own ? wshb_ifs_vga.stb : mire_own & wshb_ifs_mire.stb;
    wshb_ifm_sdram.we = vga_own ? wshb_ifs_vga.we : mire_own & wshb_ifs_mire.we;
    wshb_ifm_sdram.adr = vga_own ? wshb_ifs_vga.adr : mire_own ? wshb_ifs_mire.adr : '0;
    wshb_ifm_sdram.sel = vga_own ? wshb_ifs_vga.sel : mire_own ? wshb_ifs_mire.sel : '0;
    wshb_ifm_sdram.cti = vga_own ? wshb_ifs_vga.cti : mire_own ? wshb_ifs_mire.cti : '0;
    wshb_ifm_sdram.bte = vga_own ? wshb_ifs_vga.bte : mire_own ? wshb_ifs_mire.bte : '0;
    wshb_ifm_sdram.dat_ms = vga_own ? wshb_ifs_vga.dat_ms : mire_own ? wshb_ifs_mire.dat_ms : '0;
  end
  // return sdram responses to the owner only; the other side just sees wait states
  always_comb begin
    wshb_ifs_vga.ack = vga_own & wshb_ifm_sdram.ack;
    wshb_ifs_vga.err = vga_own & wshb_ifm_sdram.err;
    wshb_ifs_vga.rty = vga_own & wshb_ifm_sdram.rty;
    wshb_ifs_vga.dat_sm = vga_own ? wshb_ifm_sdram.dat_sm : '0;
    wshb_ifs_mire.ack = mire_own & wshb_ifm_sdram.ack;
    wshb_ifs_mire.err = mire_own & wshb_ifm_sdram.err;
    wshb_ifs_mire.rty = mire_own & wshb_ifm_sdram.rty;
    wshb_ifs_mire.dat_sm = mire_own ? wshb_ifm_sdram.dat_sm : '0;
  end
endmodule
